// File: rtl/uart_rx_oversampled.sv
// UART receiver (8N1 default) with an oversampled mid-bit sampler and a 1-entry valid/ready holding register.
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit (even, or odd with ODD_PARITY=1) and the parity_err port.
module uart_rx_oversampled #(
   parameter int CLOCK_RATE    = 25000000,
   parameter int BAUD_RATE     = 115200,
   parameter int OVER_SAMPLING = 16,
   parameter int DATA_BITS     = 8
`ifdef UART_RX_PARITY_EN
   ,
   parameter int ODD_PARITY    = 0
`endif
) (
   input  logic                 PCLK,
   input  logic                 PRESETn,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun_err,
`ifdef UART_RX_PARITY_EN
   output logic                 parity_err,
`endif
   output logic                 busy
);

   localparam int DIV   = CLOCK_RATE / (OVER_SAMPLING * BAUD_RATE);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SC_W  = $clog2(OVER_SAMPLING);
   localparam int BIT_W = $clog2(DATA_BITS);

   localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(DIV - 1);
   localparam logic [SC_W-1:0]  SC_LAST      = SC_W'(OVER_SAMPLING - 1);
   localparam logic [SC_W-1:0]  SAMPLE_POINT = SC_W'(OVER_SAMPLING / 2 - 1);
   localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(DATA_BITS - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic       ODD_BIT = (ODD_PARITY != 0);
`endif

   logic                 syncA;
   logic                 rs;
   logic [2:0]           state;
   logic [DIV_W-1:0]     divCnt;
   logic [SC_W-1:0]      sc;
   logic [BIT_W-1:0]     bitIdx;
   logic [DATA_BITS-1:0] shReg;
   logic                 tick;
   logic                 sampleNow;
   logic                 startDet;
   logic                 complete;
   logic                 drain;
`ifdef UART_RX_PARITY_EN
   logic                 parBit;
`endif

   assign tick      = (divCnt == DIV_LAST);
   assign sampleNow = tick && (sc == SAMPLE_POINT);
   assign startDet  = (state == IDLE) && !rs;
   assign complete  = (state == STOP) && sampleNow;
   assign drain     = rx_valid && rx_ready;
   assign busy      = (state != IDLE);

   // rxd is asynchronous; idle-high reset value keeps reset from looking like a start edge
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         syncA <= 1'b1;
         rs    <= 1'b1;
      end else begin
         syncA <= rxd;
         rs    <= syncA;
      end
   end

   // Restarting the divider on the start edge puts every sample a fixed half bit after it
   always_ff @(posedge PCLK) begin
      if (!PRESETn || startDet) begin
         divCnt <= '0;
         sc     <= '0;
      end else begin
         divCnt <= tick ? '0 : divCnt + 1'b1;
         if (tick) begin
            sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state  <= IDLE;
         bitIdx <= '0;
         shReg  <= '0;
`ifdef UART_RX_PARITY_EN
         parBit <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (!rs) begin
                  state <= START;
               end
            end
            START: begin
               if (sampleNow) begin
                  bitIdx <= '0;
                  state  <= rs ? IDLE : DATA;
               end
            end
            DATA: begin
               if (sampleNow) begin
                  shReg <= {rs, shReg[DATA_BITS-1:1]};
                  if (bitIdx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end else begin
                     bitIdx <= bitIdx + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (sampleNow) begin
                  parBit <= rs;
                  state  <= STOP;
               end
            end
`endif
            STOP: begin
               // Leave at mid-stop so a back-to-back start edge is not missed
               if (sampleNow) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err  <= 1'b0;
`endif
      end else begin
         if (complete && (!rx_valid || rx_ready)) begin
            rx_data    <= shReg;
            frame_err  <= ~rs;
            rx_valid   <= 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err <= (^shReg) ^ parBit ^ ODD_BIT;
`endif
         end else if (drain) begin
            rx_valid <= 1'b0;
         end

         if (complete && rx_valid && !rx_ready) begin
            overrun_err <= 1'b1;
         end else if (drain) begin
            overrun_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench for uart_rx_oversampled: table-driven frames, hand-written corner sequences
// and randomized frames scored against a byte-level model of the serial line.
module tb_uart_rx_oversampled;

   localparam int BIT_CYC = 208;
`ifdef UART_RX_PARITY_EN
   localparam int PRE_STOP_BITS = 10;
`else
   localparam int PRE_STOP_BITS = 9;
`endif
   // start edge -> mid stop bit, plus 2 sync flops and the output register
   localparam int LATENCY = PRE_STOP_BITS * BIT_CYC + BIT_CYC / 2 + 3;

   logic       PCLK = 1'b0;
   logic       PRESETn = 1'b0;
   logic       rxd = 1'b1;
   logic       rx_ready = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun_err;
   logic       busy;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         startCyc = 0;
   int         riseCyc = 0;
   logic       prevValid = 1'b0;
   logic [8:0] gotQ[$];
   logic [8:0] expQ[$];

   typedef struct {
      logic [7:0] data;
      bit         stopOk;
      logic [7:0] expData;
      bit         expFe;
   } vec_t;
   vec_t vecs[8];

   uart_rx_oversampled dut (
      .PCLK        (PCLK),
      .PRESETn     (PRESETn),
      .rxd         (rxd),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .frame_err   (frame_err),
      .overrun_err (overrun_err),
`ifdef UART_RX_PARITY_EN
      .parity_err  (parity_err),
`endif
      .busy        (busy)
   );

   always #5 PCLK = ~PCLK;

   always @(posedge PCLK) cyc <= cyc + 1;

   // Log every new byte arriving in the holding register
   always @(negedge PCLK) begin
      if (rx_valid && !prevValid) begin
         gotQ.push_back({frame_err, rx_data});
         riseCyc <= cyc;
      end
      prevValid <= rx_valid;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic holdLine(input logic val, input int n);
      rxd = val;
      repeat (n) @(negedge PCLK);
   endtask

   task automatic sendFrame(input logic [7:0] d, input bit stopOk, input int bitLen,
                            input int gap, input bit parFlip);
      startCyc = cyc;
      holdLine(1'b0, bitLen);
      for (int i = 0; i < 8; i++) holdLine(d[i], bitLen);
`ifdef UART_RX_PARITY_EN
      holdLine((^d) ^ parFlip, bitLen);
`else
      if (parFlip) holdLine(1'b1, 0);
`endif
      if (stopOk) holdLine(1'b1, bitLen);
      else        holdLine(1'b0, (3 * bitLen) / 4);
      holdLine(1'b1, gap);
   endtask

   initial begin
      logic [7:0] d;
      bit         ok;
      int         len;
      int         gap;

      vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
      vecs[1] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
      vecs[2] = '{8'h96, 1'b1, 8'h96, 1'b0};
      vecs[3] = '{8'h00, 1'b1, 8'h00, 1'b0};
      vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
      vecs[5] = '{8'h80, 1'b1, 8'h80, 1'b0};
      vecs[6] = '{8'h01, 1'b0, 8'h01, 1'b1};
      vecs[7] = '{8'h5E, 1'b1, 8'h5E, 1'b0};

      // Reset state
      repeat (4) @(negedge PCLK);
      check("rst_data", rx_data, 0);
      check("rst_valid", rx_valid, 0);
      check("rst_fe", frame_err, 0);
      check("rst_ovr", overrun_err, 0);
      check("rst_busy", busy, 0);
      PRESETn = 1'b1;
      holdLine(1'b1, 20);

      // Table-driven frames, consumer always ready
      for (int i = 0; i < 8; i++) begin
         gotQ.delete();
         sendFrame(vecs[i].data, vecs[i].stopOk, BIT_CYC, vecs[i].stopOk ? 20 : BIT_CYC, 1'b0);
         check("vec_count", gotQ.size(), 1);
         if (gotQ.size() > 0) begin
            check("vec_data", gotQ[0][7:0], vecs[i].expData);
            check("vec_fe_logged", gotQ[0][8], vecs[i].expFe);
         end
         check("vec_fe_port", frame_err, vecs[i].expFe);
         check("vec_latency", riseCyc - startCyc, LATENCY);
         check("vec_ovr", overrun_err, 0);
         check("vec_valid_low", rx_valid, 0);
         check("vec_busy_low", busy, 0);
      end

      // Short low glitch: START rejects it at mid-bit
      gotQ.delete();
      holdLine(1'b0, 50);
      check("glitch_busy_hi", busy, 1);
      holdLine(1'b1, 150);
      check("glitch_busy_lo", busy, 0);
      check("glitch_no_byte", gotQ.size(), 0);
      check("glitch_valid", rx_valid, 0);

      // Drain and load in the same cycle keeps rx_valid high with the new byte
      gotQ.delete();
      rx_ready = 1'b0;
      sendFrame(8'h6B, 1'b1, BIT_CYC, 0, 1'b0);
      check("dl_first_valid", rx_valid, 1);
      check("dl_first_data", rx_data, 8'h6B);
      fork
         sendFrame(8'hC4, 1'b1, BIT_CYC, 20, 1'b0);
         begin
            repeat (LATENCY - 1) @(negedge PCLK);
            rx_ready = 1'b1;
            @(negedge PCLK);
            rx_ready = 1'b0;
         end
      join
      check("dl_valid", rx_valid, 1);
      check("dl_data", rx_data, 8'hC4);
      check("dl_ovr", overrun_err, 0);
      rx_ready = 1'b1;
      holdLine(1'b1, 1);
      rx_ready = 1'b0;
      check("dl_drained", rx_valid, 0);

      // Overrun: second byte dropped while holding register is full
      gotQ.delete();
      sendFrame(8'h11, 1'b1, BIT_CYC, 0, 1'b0);
      check("ovr_first_valid", rx_valid, 1);
      check("ovr_first_flag", overrun_err, 0);
      sendFrame(8'h22, 1'b1, BIT_CYC, 20, 1'b0);
      check("ovr_valid", rx_valid, 1);
      check("ovr_data_held", rx_data, 8'h11);
      check("ovr_flag", overrun_err, 1);
      check("ovr_arrivals", gotQ.size(), 1);
      rx_ready = 1'b1;
      holdLine(1'b1, 1);
      rx_ready = 1'b0;
      check("ovr_valid_clr", rx_valid, 0);
      check("ovr_flag_clr", overrun_err, 0);
      holdLine(1'b1, 5);
      check("ovr_valid_stays", rx_valid, 0);

      // Reset mid-frame after leaving outputs non-zero
      sendFrame(8'h3C, 1'b0, BIT_CYC, BIT_CYC, 1'b0);
      check("prerst_valid", rx_valid, 1);
      check("prerst_fe", frame_err, 1);
      rx_ready = 1'b1;
      gotQ.delete();
      d = 8'h5A;
      holdLine(1'b0, BIT_CYC);
      for (int i = 0; i < 4; i++) holdLine(d[i], BIT_CYC);
      holdLine(d[4], 100);
      check("midrst_busy", busy, 1);
      PRESETn = 1'b0;
      holdLine(1'b1, 1);
      PRESETn = 1'b1;
      check("midrst_data", rx_data, 0);
      check("midrst_valid", rx_valid, 0);
      check("midrst_fe", frame_err, 0);
      check("midrst_ovr", overrun_err, 0);
      check("midrst_busy0", busy, 0);
      holdLine(1'b1, 300);
      check("midrst_no_partial", gotQ.size(), 0);
      sendFrame(8'h5A, 1'b1, BIT_CYC, 20, 1'b0);
      check("postrst_count", gotQ.size(), 1);
      if (gotQ.size() > 0) check("postrst_byte", gotQ[0], {1'b0, 8'h5A});

`ifdef UART_RX_PARITY_EN
      // Even parity: 0x07 carries three ones, so parity bit 0 is wrong
      sendFrame(8'h07, 1'b1, BIT_CYC, 20, 1'b1);
      check("par_bad", parity_err, 1);
      sendFrame(8'h07, 1'b1, BIT_CYC, 20, 1'b0);
      check("par_good", parity_err, 0);
`endif

      // Randomized frames with bit-rate skew; every frame is expected once with frame_err = !stop
      gotQ.delete();
      expQ.delete();
      for (int i = 0; i < 10; i++) begin
         d   = 8'($urandom_range(0, 255));
         ok  = ($urandom_range(0, 3) != 0);
         len = ok ? int'($urandom_range(202, 214)) : BIT_CYC;
         gap = ok ? int'($urandom_range(0, 60)) : BIT_CYC + int'($urandom_range(0, 60));
         expQ.push_back({~ok, d});
         sendFrame(d, ok, len, gap, 1'b0);
      end
      holdLine(1'b1, 50);
      check("rand_count", gotQ.size(), expQ.size());
      for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
         check("rand_byte", gotQ[i], expQ[i]);
      end
      check("rand_ovr", overrun_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
